// File: rtl/pag_tlb_sa.sv
// pag_tlb_sa: set-associative page translation buffer with refill FSM and set-by-set sweep engine.
module pag_tlb_sa #(
  parameter int VPN_W = 13,
  parameter int PPN_W = 13,
  parameter int SETS  = 128,
  parameter int WAYS  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lk_valid,
  input  logic [VPN_W-1:0]   lk_vpn,
  input  logic               lk_user,
  input  logic               lk_write,
  input  logic               lk_paged,
  output logic               lk_ready,
  output logic               lk_done,
  output logic               lk_hit,
  output logic [PPN_W-1:0]   lk_ppn,
  output logic [4:0]         lk_acc,
  output logic               lk_fail,
  output logic [5:0]         lk_fail_code,
  output logic               rf_req,
  output logic [VPN_W-1:0]   rf_vpn,
  output logic               rf_user,
  input  logic               rf_ack,
  input  logic [PPN_W+4:0]   rf_data,
  input  logic               rf_err,
  input  logic               wr_valid,
  input  logic [VPN_W-1:0]   wr_vpn,
  input  logic               wr_user,
  input  logic [PPN_W+4:0]   wr_data,
  input  logic               sw_start,
  input  logic               sw_user_only,
  output logic               sw_busy,
  output logic               par_err
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int PW    = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef struct packed {
    logic             par;
    logic             user;
    logic [TAG_W-1:0] tag;
    logic [4:0]       acc;
    logic [PPN_W-1:0] ppn;
  } ent_t;
  typedef enum logic [1:0] {IDLE, REFILL, SWEEP} st_t;
  st_t                        state;
  ent_t [WAYS-1:0][SETS-1:0]  mem;
  logic [SETS-1:0][WAYS-1:0]  vld;
  logic [SETS-1:0][PW-1:0]    rr;
  logic [IDX_W-1:0]           sw_cnt;
  logic                       sw_pend, sw_uo, rf_write;
  logic [IDX_W-1:0]           l_idx, w_idx;
  logic [TAG_W-1:0]           l_tag, w_tag;
  logic [WAYS-1:0]            l_m, w_m, s_m;
  logic [PW-1:0]              l_way, m_way, i_way, w_way;
  logic                       l_any, l_perr, l_deny, rf_wen, w_en, w_user, w_hit, w_inv;
  logic [VPN_W-1:0]           w_vpn;
  logic [PPN_W+4:0]           w_data;
  ent_t                       l_e, w_e;
  assign lk_ready = (state == IDLE) & ~wr_valid;
  assign sw_busy  = state == SWEEP;
  assign l_idx    = lk_vpn[IDX_W-1:0];
  assign l_tag    = lk_vpn[VPN_W-1:IDX_W];
  assign rf_wen   = (state == REFILL) & rf_ack & ~rf_err;
  assign w_en     = rf_wen | wr_valid;
  assign w_vpn    = rf_wen ? rf_vpn : wr_vpn;
  assign w_user   = rf_wen ? rf_user : wr_user;
  assign w_data   = rf_wen ? rf_data : wr_data;
  assign w_idx    = w_vpn[IDX_W-1:0];
  assign w_tag    = w_vpn[VPN_W-1:IDX_W];
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign l_m[g] = vld[l_idx][g] & (mem[g][l_idx].tag == l_tag) & (mem[g][l_idx].user == lk_user);
    assign w_m[g] = vld[w_idx][g] & (mem[g][w_idx].tag == w_tag) & (mem[g][w_idx].user == w_user);
    assign s_m[g] = ~sw_uo | mem[g][sw_cnt].user;
  end
  // descending scan leaves the lowest qualifying way in each selector
  always_comb begin
    l_way = '0;
    m_way = '0;
    i_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      l_way = l_m[PW'(w)] ? PW'(w) : l_way;
      m_way = w_m[PW'(w)] ? PW'(w) : m_way;
      i_way = vld[w_idx][PW'(w)] ? i_way : PW'(w);
    end
  end
  assign l_any  = |l_m;
  assign w_hit  = |w_m;
  assign w_inv  = ~&vld[w_idx];
  assign w_way  = w_hit ? m_way : w_inv ? i_way : rr[w_idx];
  assign l_e    = mem[l_way][l_idx];
  assign l_perr = ~^l_e;
  assign l_deny = ~l_e.acc[4] | (lk_write & ~l_e.acc[2]);
  assign w_e    = {~^{w_user, w_tag, w_data}, w_user, w_tag, w_data};
  always_ff @(posedge clk) begin
    if (w_en) mem[w_way][w_idx] <= w_e;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      vld          <= '0;
      rr           <= '0;
      sw_cnt       <= '0;
      sw_pend      <= 1'b0;
      sw_uo        <= 1'b0;
      rf_req       <= 1'b0;
      rf_vpn       <= '0;
      rf_user      <= 1'b0;
      rf_write     <= 1'b0;
      lk_done      <= 1'b0;
      lk_hit       <= 1'b0;
      lk_ppn       <= '0;
      lk_acc       <= '0;
      lk_fail      <= 1'b0;
      lk_fail_code <= '0;
      par_err      <= 1'b0;
    end else begin
      lk_done      <= 1'b0;
      lk_hit       <= 1'b0;
      lk_ppn       <= '0;
      lk_acc       <= '0;
      lk_fail      <= 1'b0;
      lk_fail_code <= '0;
      par_err      <= 1'b0;
      if (sw_start && state != SWEEP) sw_uo <= sw_user_only;
      if (lk_valid && lk_ready) begin
        lk_done <= 1'b1;
        if (!lk_paged) begin
          lk_hit <= 1'b1;
          lk_ppn <= PPN_W'(lk_vpn);
          lk_acc <= 5'b11110;
        end else if (l_any && l_perr) begin
          lk_fail           <= 1'b1;
          lk_fail_code      <= {1'b1, l_e.acc[4], l_e.acc[2], l_e.acc[1], lk_write, lk_user};
          par_err           <= 1'b1;
          vld[l_idx][l_way] <= 1'b0;
        end else if (l_any) begin
          lk_hit       <= 1'b1;
          lk_ppn       <= l_e.ppn;
          lk_acc       <= l_e.acc;
          lk_fail      <= l_deny;
          lk_fail_code <= l_deny ? {1'b0, l_e.acc[4], l_e.acc[2], l_e.acc[1], lk_write, lk_user} : '0;
        end else if (!(sw_start || sw_pend)) begin
          state    <= REFILL;
          rf_req   <= 1'b1;
          rf_vpn   <= lk_vpn;
          rf_user  <= lk_user;
          rf_write <= lk_write;
        end
      end
      case (state)
        IDLE: if (sw_start || sw_pend) begin
          state   <= SWEEP;
          sw_cnt  <= '0;
          sw_pend <= 1'b0;
        end
        REFILL: begin
          if (sw_start) sw_pend <= 1'b1;
          if (rf_ack) begin
            state  <= IDLE;
            rf_req <= 1'b0;
            if (rf_err) begin
              lk_done      <= 1'b1;
              lk_fail      <= 1'b1;
              lk_fail_code <= {4'b1000, rf_write, rf_user};
            end
          end
        end
        default: begin
          vld[sw_cnt] <= vld[sw_cnt] & ~s_m;
          sw_cnt      <= sw_cnt + 1'b1;
          if (sw_cnt == IDX_W'(SETS - 1)) state <= IDLE;
        end
      endcase
      if (w_en) begin
        vld[w_idx][w_way] <= 1'b1;
        if (!w_hit) rr[w_idx] <= WAYS == 1 ? '0 : rr[w_idx] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pag_tlb_sa.sv
// tb_pag_tlb_sa: randomized and directed checks of pag_tlb_sa against a per-set way-array model.
module tb_pag_tlb_sa;
  localparam int SETS = 128;
  localparam int WAYS = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_valid = 1'b0, lk_user = 1'b0, lk_write = 1'b0, lk_paged = 1'b0;
  logic [12:0] lk_vpn = '0;
  logic        lk_ready, lk_done, lk_hit, lk_fail, rf_req, rf_user, sw_busy, par_err;
  logic [12:0] lk_ppn, rf_vpn;
  logic [4:0]  lk_acc;
  logic [5:0]  lk_fail_code;
  logic        rf_ack = 1'b0, rf_err = 1'b0, wr_valid = 1'b0, wr_user = 1'b0;
  logic [17:0] rf_data = '0, wr_data = '0;
  logic [12:0] wr_vpn = '0;
  logic        sw_start = 1'b0, sw_user_only = 1'b0;
  pag_tlb_sa dut (
    .clk(clk), .rst(rst), .lk_valid(lk_valid), .lk_vpn(lk_vpn), .lk_user(lk_user),
    .lk_write(lk_write), .lk_paged(lk_paged), .lk_ready(lk_ready), .lk_done(lk_done),
    .lk_hit(lk_hit), .lk_ppn(lk_ppn), .lk_acc(lk_acc), .lk_fail(lk_fail),
    .lk_fail_code(lk_fail_code), .rf_req(rf_req), .rf_vpn(rf_vpn), .rf_user(rf_user),
    .rf_ack(rf_ack), .rf_data(rf_data), .rf_err(rf_err), .wr_valid(wr_valid),
    .wr_vpn(wr_vpn), .wr_user(wr_user), .wr_data(wr_data), .sw_start(sw_start),
    .sw_user_only(sw_user_only), .sw_busy(sw_busy), .par_err(par_err)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  bit          mv[SETS][WAYS], mu[SETS][WAYS], mbad[SETS][WAYS];
  logic [5:0]  mt[SETS][WAYS];
  logic [4:0]  ma[SETS][WAYS];
  logic [12:0] mp[SETS][WAYS];
  int          mrr[SETS];
  bit          miss, p_user, p_write;
  logic [12:0] p_vpn;
  logic [WAYS-1:0][SETS-1:0][25:0] fm;
  logic [6:0]  ix[4] = '{7'd3, 7'd5, 7'd9, 7'd127};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int find(input logic [12:0] vpn, input bit u);
    int s = int'(vpn[6:0]);
    find = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (mv[s][w] && mu[s][w] == u && mt[s][w] == vpn[12:7]) find = w;
  endfunction
  // install rule: matching way in place, else lowest invalid, else round-robin victim
  task automatic m_write(input logic [12:0] vpn, input bit u, input logic [17:0] d);
    int s = int'(vpn[6:0]);
    int w = find(vpn, u);
    if (w < 0) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) w = i;
      if (w < 0) w = mrr[s];
      mrr[s] = (mrr[s] + 1) % WAYS;
    end
    mv[s][w] = 1; mu[s][w] = u; mt[s][w] = vpn[12:7]; ma[s][w] = d[17:13]; mp[s][w] = d[12:0];
    mbad[s][w] = 0;
  endtask
  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin mv[s][w] = 0; mbad[s][w] = 0; end
    end
  endtask
  task automatic lookup(input logic [12:0] vpn, input bit u, input bit wr, input bit paged);
    int s = int'(vpn[6:0]);
    int w = find(vpn, u);
    bit f;
    miss = 0;
    @(negedge clk);
    lk_valid = 1; lk_vpn = vpn; lk_user = u; lk_write = wr; lk_paged = paged;
    @(negedge clk);
    lk_valid = 0;
    check("lk_done", lk_done, 1);
    if (!paged) begin
      check("up_hit", lk_hit, 1);
      check("up_ppn", lk_ppn, vpn);
      check("up_acc", lk_acc, 5'b11110);
      check("up_fail", lk_fail, 0);
    end else if (w >= 0 && mbad[s][w]) begin
      check("pe_hit", lk_hit, 0);
      check("pe_fail", lk_fail, 1);
      check("pe_code5", lk_fail_code[5], 1);
      check("pe_pulse", par_err, 1);
      mv[s][w] = 0; mbad[s][w] = 0;
    end else if (w >= 0) begin
      f = !ma[s][w][4] || (wr && !ma[s][w][2]);
      check("hit", lk_hit, 1);
      check("hit_ppn", lk_ppn, mp[s][w]);
      check("hit_acc", lk_acc, ma[s][w]);
      check("hit_fail", lk_fail, f);
      if (f) check("hit_code", lk_fail_code, {1'b0, ma[s][w][4], ma[s][w][2], ma[s][w][1], wr, u});
      check("hit_norf", rf_req, 0);
    end else begin
      check("miss_hit", lk_hit, 0);
      check("miss_fail", lk_fail, 0);
      check("miss_rfreq", rf_req, 1);
      check("miss_rfvpn", rf_vpn, vpn);
      check("miss_rfuser", rf_user, u);
      miss = 1; p_vpn = vpn; p_user = u; p_write = wr;
    end
  endtask
  task automatic refill(input bit err, input logic [17:0] d);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    check("rf_hold", rf_req, 1);
    rf_ack = 1; rf_err = err; rf_data = d;
    @(negedge clk);
    rf_ack = 0; rf_err = 0;
    check("rf_drop", rf_req, 0);
    if (err) begin
      check("rfe_done", lk_done, 1);
      check("rfe_fail", lk_fail, 1);
      check("rfe_hit", lk_hit, 0);
      check("rfe_code", lk_fail_code, {4'b1000, p_write, p_user});
    end else begin
      check("rf_nodone", lk_done, 0);
      m_write(p_vpn, p_user, d);
    end
  endtask
  task automatic wr(input logic [12:0] vpn, input bit u, input logic [17:0] d, input bit with_lk);
    @(negedge clk);
    wr_valid = 1; wr_vpn = vpn; wr_user = u; wr_data = d;
    lk_valid = with_lk; lk_vpn = vpn; lk_paged = 0;
    #1 check("wr_ready", lk_ready, 0);
    @(negedge clk);
    wr_valid = 0; lk_valid = 0;
    check("wr_nolk", lk_done, 0);
    m_write(vpn, u, d);
  endtask
  // counts busy samples from the current negedge; a stray sw_start mid-sweep must not extend it
  task automatic busy_count();
    int n = 0;
    while (sw_busy && n < 400) begin
      sw_start = (n == 50);
      n++;
      @(negedge clk);
    end
    sw_start = 0;
    check("sw_cycles", n, SETS);
  endtask
  task automatic sweep(input bit uo);
    @(negedge clk);
    sw_start = 1; sw_user_only = uo;
    @(negedge clk);
    sw_start = 0;
    check("sw_ready", lk_ready, 0);
    busy_count();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) if (!uo || mu[s][w]) mv[s][w] = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    logic [12:0] v;
    int pw;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_ready", lk_ready, 1);
    check("rst_done", lk_done, 0);
    check("rst_rfreq", rf_req, 0);
    check("rst_busy", sw_busy, 0);
    check("rst_perr", par_err, 0);
    check("rst_hit", lk_hit, 0);
    // miss then refill then hit
    lookup(13'h0123, 1, 0, 1);
    check("t1_miss", miss, 1);
    refill(0, {5'b11101, 13'h0456});
    lookup(13'h0123, 1, 0, 1);
    check("t1_ppn", lk_ppn, 13'h0456);
    // write protect
    wr(13'h0190, 1, {5'b11001, 13'h0111}, 0);
    lookup(13'h0190, 1, 1, 1);
    check("t2_code", lk_fail_code, 6'b010011);
    // replacement in set 5
    foreach (ix[i]) begin end
    for (int t = 1; t <= 3; t++) begin
      lookup({6'(t), 7'd5}, 0, 0, 1);
      refill(0, {5'b10101, 13'(t * 16)});
    end
    lookup({6'd2, 7'd5}, 0, 0, 1);
    check("t3_hit2", lk_hit, 1);
    lookup({6'd3, 7'd5}, 0, 0, 1);
    check("t3_hit3", lk_hit, 1);
    check("t3_rr5", dut.rr[5], 1);
    lookup({6'd1, 7'd5}, 0, 0, 1);
    check("t3_evicted", miss, 1);
    refill(0, {5'b10101, 13'h0777});
    // user-only sweep over mixed entries
    wr(13'h0A40, 1, {5'b11111, 13'h0001}, 0);
    wr(13'h0A41, 0, {5'b11111, 13'h0002}, 0);
    sweep(1);
    lookup(13'h0A40, 1, 0, 1);
    check("t4_user_miss", miss, 1);
    refill(1, '0);
    lookup(13'h0A41, 0, 0, 1);
    check("t4_exec_hit", lk_hit, 1);
    // parity corruption on a stored ppn bit
    wr(13'h0A0C, 0, {5'b11111, 13'h1ABC}, 0);
    pw = find(13'h0A0C, 0);
    fm = dut.mem;
    fm[pw][12][0] = ~fm[pw][12][0];
    force dut.mem = fm;
    mbad[12][pw] = 1;
    lookup(13'h0A0C, 0, 0, 1);
    @(negedge clk);
    check("pe_once", par_err, 0);
    release dut.mem;
    lookup(13'h0A0C, 0, 0, 1);
    check("pe_then_miss", miss, 1);
    refill(0, {5'b11111, 13'h1ABC});
    // sweep requested during refill runs after the ack
    lookup(13'h1F33, 0, 0, 1);
    @(negedge clk);
    sw_start = 1; sw_user_only = 0;
    @(negedge clk);
    sw_start = 0;
    check("pend_nobusy", sw_busy, 0);
    refill(0, {5'b10100, 13'h0042});
    check("pend_idle", sw_busy, 0);
    @(negedge clk);
    check("pend_start", sw_busy, 1);
    busy_count();
    m_reset();
    lookup(13'h1F33, 0, 0, 1);
    check("pend_cleared", miss, 1);
    refill(0, {5'b10100, 13'h0042});
    // direct write collides with lookup
    wr(13'h0C07, 1, {5'b10110, 13'h0C07}, 1);
    // reset mid-sweep
    @(negedge clk);
    sw_start = 1;
    @(negedge clk);
    sw_start = 0;
    repeat (20) @(negedge clk);
    rst = 1;
    #1 check("rsw_busy", sw_busy, 0);
    @(negedge clk);
    rst = 0;
    m_reset();
    check("rsw_ready", lk_ready, 1);
    lookup(13'h0C07, 1, 0, 1);
    check("rsw_miss", miss, 1);
    // reset mid-refill
    rst = 1;
    #1 check("rrf_rfreq", rf_req, 0);
    @(negedge clk);
    rst = 0;
    m_reset();
    check("rrf_ready", lk_ready, 1);
    // randomized mix
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      v = {6'($urandom_range(0, 3)), ix[$urandom_range(0, 3)]};
      if (r < 6) begin
        lookup(v, 1'($urandom), 1'($urandom), 1);
        if (miss) refill($urandom_range(0, 7) == 0, 18'($urandom));
      end else if (r < 8) wr(v, 1'($urandom), 18'($urandom), 1'($urandom));
      else if (r == 9 && $urandom_range(0, 9) == 0) sweep(1'($urandom));
      else lookup(13'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
